// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-bank writeback arbiter.
//   DATA_WIDTH_DEF    : default writeback / bank word width
//   REG_ADDR_BITS_DEF : default register address width
//   NUM_REGS_DEF      : number of architectural registers (scoreboard depth)
//   port_sel_e        : encoding of the two writeback requesters
package regfile_wb_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 32;
  localparam int unsigned REG_ADDR_BITS_DEF = 5;
  localparam int unsigned NUM_REGS_DEF      = 1 << REG_ADDR_BITS_DEF;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for destinations of in-flight long-latency ops.
//   clk, reset           : clock, synchronous active-high reset
//   issue_valid/issue_rd : marks issue_rd busy at the edge (x0 ignored)
//   clr_en/clr_addr      : clears clr_addr busy at the edge (bank commit)
//   chk_rs1/rs2/rd       : operands looked up for the hazard flag
//   hazard               : any checked register busy (combinational)
//   busy_vec             : scoreboard contents
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned REG_ADDR_BITS = REG_ADDR_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [REG_ADDR_BITS-1:0]   issue_rd,
  input  logic                       clr_en,
  input  logic [REG_ADDR_BITS-1:0]   clr_addr,
  input  logic [REG_ADDR_BITS-1:0]   chk_rs1,
  input  logic [REG_ADDR_BITS-1:0]   chk_rs2,
  input  logic [REG_ADDR_BITS-1:0]   chk_rd,
  output logic                       hazard,
  output logic [(1<<REG_ADDR_BITS)-1:0] busy_vec
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_BITS;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // Clear first so a same-cycle set of the same index wins; x0 is never busy.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) begin
      busy_nxt[clr_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  // Lookup uses registered state only; no bypass of the same-cycle write.
  assign hazard   = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register bank write port between the ALU
// (port A) and the load/multiply unit (port B), with a registered write
// stage and a busy scoreboard for decode hazard detection.
//   clk, reset                      : clock, synchronous active-high reset
//   a_valid/a_rd/a_data/a_ready     : port A writeback handshake
//   b_valid/b_rd/b_data/b_ready     : port B writeback handshake
//   issue_valid/issue_rd            : long-latency op issue (marks rd busy)
//   chk_rs1/chk_rs2/chk_rd, hazard  : decode operand busy check
//   register_enable_write/address/data : registered bank write port
//   busy_vec                        : scoreboard contents for debug
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned REG_ADDR_BITS = REG_ADDR_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_valid,
  input  logic [REG_ADDR_BITS-1:0]      a_rd,
  input  logic [DATA_WIDTH-1:0]         a_data,
  output logic                          a_ready,
  input  logic                          b_valid,
  input  logic [REG_ADDR_BITS-1:0]      b_rd,
  input  logic [DATA_WIDTH-1:0]         b_data,
  output logic                          b_ready,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_BITS-1:0]      issue_rd,
  input  logic [REG_ADDR_BITS-1:0]      chk_rs1,
  input  logic [REG_ADDR_BITS-1:0]      chk_rs2,
  input  logic [REG_ADDR_BITS-1:0]      chk_rd,
  output logic                          hazard,
  output logic                          register_enable_write,
  output logic [REG_ADDR_BITS-1:0]      register_address_to_write,
  output logic [DATA_WIDTH-1:0]         register_data_to_write,
  output logic [(1<<REG_ADDR_BITS)-1:0] busy_vec
);

  port_sel_e                last_grant_q;
  logic                     grant;
  logic [REG_ADDR_BITS-1:0] grant_rd;
  logic [DATA_WIDTH-1:0]    grant_data;

  // One grant per cycle; on contention the port not granted last wins.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (a_valid && b_valid) begin
      if (last_grant_q == PORT_B) begin
        a_ready = 1'b1;
      end else begin
        b_ready = 1'b1;
      end
    end else begin
      a_ready = a_valid;
      b_ready = b_valid;
    end
  end

  assign grant      = a_ready | b_ready;
  assign grant_rd   = a_ready ? a_rd   : b_rd;
  assign grant_data = a_ready ? a_data : b_data;

  // Pointer resets to B so that A is favoured first; it moves only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= PORT_B;
    end else if (grant) begin
      last_grant_q <= a_ready ? PORT_A : PORT_B;
    end
  end

  // Write stage: a grant to x0 is consumed but never reaches the bank,
  // and address/data hold whenever nothing is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      register_enable_write     <= 1'b0;
      register_address_to_write <= '0;
      register_data_to_write    <= '0;
    end else if (grant && (grant_rd != '0)) begin
      register_enable_write     <= 1'b1;
      register_address_to_write <= grant_rd;
      register_data_to_write    <= grant_data;
    end else begin
      register_enable_write     <= 1'b0;
    end
  end

  // Busy bits clear on the same edge the bank commits the write.
  regfile_scoreboard #(
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clr_en      (register_enable_write),
    .clr_addr    (register_address_to_write),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .chk_rd      (chk_rd),
    .hazard      (hazard),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter. Each row is one clock
// cycle: inputs driven just after the rising edge, outputs sampled on the
// falling edge. Registered outputs in a row reflect the previous rows.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_rd, b_rd, issue_rd, chk_rs1, chk_rs2, chk_rd;
  logic [DW-1:0] a_data, b_data;
  logic          issue_valid, hazard;
  logic          register_enable_write;
  logic [AW-1:0] register_address_to_write;
  logic [DW-1:0] register_data_to_write;
  logic [NR-1:0] busy_vec;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_BITS(AW)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .a_valid                   (a_valid),
    .a_rd                      (a_rd),
    .a_data                    (a_data),
    .a_ready                   (a_ready),
    .b_valid                   (b_valid),
    .b_rd                      (b_rd),
    .b_data                    (b_data),
    .b_ready                   (b_ready),
    .issue_valid               (issue_valid),
    .issue_rd                  (issue_rd),
    .chk_rs1                   (chk_rs1),
    .chk_rs2                   (chk_rs2),
    .chk_rd                    (chk_rd),
    .hazard                    (hazard),
    .register_enable_write     (register_enable_write),
    .register_address_to_write (register_address_to_write),
    .register_data_to_write    (register_data_to_write),
    .busy_vec                  (busy_vec)
  );

  typedef struct {
    logic          a_valid;
    logic [AW-1:0] a_rd;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic [AW-1:0] b_rd;
    logic [DW-1:0] b_data;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] rs1, rs2, rd;
    logic          e_a_ready, e_b_ready, e_hazard, e_we;
    logic          chk_ad;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [NR-1:0] e_busy;
  } row_t;

  row_t vecs[$];

  function automatic row_t idle();
    row_t r;
    r.a_valid = 1'b0; r.a_rd = '0; r.a_data = '0;
    r.b_valid = 1'b0; r.b_rd = '0; r.b_data = '0;
    r.issue_valid = 1'b0; r.issue_rd = '0;
    r.rs1 = '0; r.rs2 = '0; r.rd = '0;
    r.e_a_ready = 1'b0; r.e_b_ready = 1'b0; r.e_hazard = 1'b0; r.e_we = 1'b0;
    r.chk_ad = 1'b1; r.e_addr = '0; r.e_data = '0; r.e_busy = '0;
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input row_t r);
    a_valid = r.a_valid; a_rd = r.a_rd; a_data = r.a_data;
    b_valid = r.b_valid; b_rd = r.b_rd; b_data = r.b_data;
    issue_valid = r.issue_valid; issue_rd = r.issue_rd;
    chk_rs1 = r.rs1; chk_rs2 = r.rs2; chk_rd = r.rd;
  endtask

  task automatic set_state(inout row_t r, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [NR-1:0] busy);
    r.e_we = we; r.e_addr = addr; r.e_data = data; r.e_busy = busy;
  endtask

  initial begin
    row_t r;
    string tag;

    // Row 0: single A request to x3
    r = idle(); r.a_valid = 1'b1; r.a_rd = 5'd3; r.a_data = 32'h11; r.e_a_ready = 1'b1;
    vecs.push_back(r);
    // Row 1: write stage shows A's write
    r = idle(); set_state(r, 1'b1, 5'd3, 32'h11, '0); vecs.push_back(r);
    // Row 2: B to x0 accepted; issue to x0; check x0 operand
    r = idle(); set_state(r, 1'b0, 5'd3, 32'h11, '0);
    r.b_valid = 1'b1; r.b_rd = 5'd0; r.b_data = 32'h99; r.e_b_ready = 1'b1;
    r.issue_valid = 1'b1; r.issue_rd = 5'd0; r.rs1 = 5'd0;
    vecs.push_back(r);
    // Rows 3..6: both valid, last grant was B -> A,B,A,B
    for (int i = 0; i < 4; i++) begin
      r = idle();
      r.a_valid = 1'b1; r.a_rd = 5'd5; r.a_data = 32'hA;
      r.b_valid = 1'b1; r.b_rd = 5'd6; r.b_data = 32'hB;
      r.e_a_ready = (i % 2 == 0); r.e_b_ready = (i % 2 == 1);
      if (i == 0) begin
        r.chk_ad = 1'b0;
      end else if (i % 2 == 1) begin
        set_state(r, 1'b1, 5'd5, 32'hA, '0);
      end else begin
        set_state(r, 1'b1, 5'd6, 32'hB, '0);
      end
      vecs.push_back(r);
    end
    // Row 7: last write of the alternation
    r = idle(); set_state(r, 1'b1, 5'd6, 32'hB, '0); vecs.push_back(r);
    // Row 8: issue long op to x7
    r = idle(); set_state(r, 1'b0, 5'd6, 32'hB, '0);
    r.issue_valid = 1'b1; r.issue_rd = 5'd7; vecs.push_back(r);
    // Row 9: x7 busy, rs2 hazard
    r = idle(); set_state(r, 1'b0, 5'd6, 32'hB, NR'(1) << 7);
    r.rs2 = 5'd7; r.e_hazard = 1'b1; vecs.push_back(r);
    // Row 10: B writes x7
    r = idle(); set_state(r, 1'b0, 5'd6, 32'hB, NR'(1) << 7);
    r.rs2 = 5'd7; r.e_hazard = 1'b1;
    r.b_valid = 1'b1; r.b_rd = 5'd7; r.b_data = 32'h55; r.e_b_ready = 1'b1;
    vecs.push_back(r);
    // Row 11: commit cycle, hazard still up (no bypass)
    r = idle(); set_state(r, 1'b1, 5'd7, 32'h55, NR'(1) << 7);
    r.rs2 = 5'd7; r.e_hazard = 1'b1; vecs.push_back(r);
    // Row 12: hazard dropped
    r = idle(); set_state(r, 1'b0, 5'd7, 32'h55, '0); r.rs2 = 5'd7; vecs.push_back(r);
    // Row 13: A writes x9
    r = idle(); set_state(r, 1'b0, 5'd7, 32'h55, '0);
    r.a_valid = 1'b1; r.a_rd = 5'd9; r.a_data = 32'hC3; r.e_a_ready = 1'b1;
    vecs.push_back(r);
    // Row 14: issue x9 while the write stage clears x9: set wins
    r = idle(); set_state(r, 1'b1, 5'd9, 32'hC3, '0);
    r.issue_valid = 1'b1; r.issue_rd = 5'd9; vecs.push_back(r);
    // Row 15: x9 remains busy
    r = idle(); set_state(r, 1'b0, 5'd9, 32'hC3, NR'(1) << 9);
    r.rd = 5'd9; r.e_hazard = 1'b1; vecs.push_back(r);
    // Row 16: issue x4
    r = idle(); set_state(r, 1'b0, 5'd9, 32'hC3, NR'(1) << 9);
    r.issue_valid = 1'b1; r.issue_rd = 5'd4; r.rs1 = 5'd9; r.e_hazard = 1'b1;
    vecs.push_back(r);
    // Row 17: A writes busy x9 (allowed, clears it)
    r = idle(); set_state(r, 1'b0, 5'd9, 32'hC3, (NR'(1) << 9) | (NR'(1) << 4));
    r.a_valid = 1'b1; r.a_rd = 5'd9; r.a_data = 32'h77; r.e_a_ready = 1'b1;
    vecs.push_back(r);
    // Row 18: commit of x9
    r = idle(); set_state(r, 1'b1, 5'd9, 32'h77, (NR'(1) << 9) | (NR'(1) << 4));
    vecs.push_back(r);
    // Row 19: only x4 left busy
    r = idle(); set_state(r, 1'b0, 5'd9, 32'h77, NR'(1) << 4);
    r.rd = 5'd4; r.e_hazard = 1'b1; vecs.push_back(r);

    // Reset
    drive(idle());
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_we", DW'(register_enable_write), '0);
    check("rst_addr", DW'(register_address_to_write), '0);
    check("rst_data", register_data_to_write, '0);
    check("rst_busy", DW'(busy_vec), '0);
    check("rst_hazard", DW'(hazard), '0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      tag = $sformatf("row%0d", i);
      check({tag, "_a_ready"}, DW'(a_ready), DW'(vecs[i].e_a_ready));
      check({tag, "_b_ready"}, DW'(b_ready), DW'(vecs[i].e_b_ready));
      check({tag, "_hazard"}, DW'(hazard), DW'(vecs[i].e_hazard));
      check({tag, "_we"}, DW'(register_enable_write), DW'(vecs[i].e_we));
      if (vecs[i].chk_ad) begin
        check({tag, "_addr"}, DW'(register_address_to_write), DW'(vecs[i].e_addr));
        check({tag, "_data"}, register_data_to_write, vecs[i].e_data);
      end
      check({tag, "_busy"}, DW'(busy_vec), DW'(vecs[i].e_busy));
      @(posedge clk); #1;
    end

    // Mid-operation reset: x4 busy, A grant pending, pointer last on A.
    r = idle(); r.a_valid = 1'b1; r.a_rd = 5'd8; r.a_data = 32'hEE;
    drive(r);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    r = idle();
    r.a_valid = 1'b1; r.a_rd = 5'd5; r.a_data = 32'hA;
    r.b_valid = 1'b1; r.b_rd = 5'd6; r.b_data = 32'hB;
    drive(r);
    @(negedge clk);
    check("mrst_we", DW'(register_enable_write), '0);
    check("mrst_addr", DW'(register_address_to_write), '0);
    check("mrst_data", register_data_to_write, '0);
    check("mrst_busy", DW'(busy_vec), '0);
    check("mrst_a_ready", DW'(a_ready), 32'd1);
    check("mrst_b_ready", DW'(b_ready), '0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_next_b_ready", DW'(b_ready), 32'd1);
    check("mrst_next_we", DW'(register_enable_write), 32'd1);
    check("mrst_next_addr", DW'(register_address_to_write), 32'd5);
    check("mrst_next_data", register_data_to_write, 32'hA);
    @(posedge clk); #1;
    drive(idle());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register bank's single write port between two writeback requesters: port A (ALU) and port B (load/multiply unit).
- Tracks destination registers of in-flight long-latency ops in a scoreboard and raises a hazard flag for decode/issue.
- Sits between the execute/writeback stages and the register bank write inputs.
- Drives the bank write enable, write address and write data from registers.

Parameters:
- DATA_WIDTH, 32: writeback data width; equals the bank word width.
- REG_ADDR_BITS, 5: register address width; the scoreboard has 2**REG_ADDR_BITS entries.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  port A has a writeback pending.
- a_rd  in  REG_ADDR_BITS  port A destination register.
- a_data  in  DATA_WIDTH  port A write data.
- a_ready  out  1  port A granted this cycle (combinational).
- b_valid  in  1  port B has a writeback pending.
- b_rd  in  REG_ADDR_BITS  port B destination register.
- b_data  in  DATA_WIDTH  port B write data.
- b_ready  out  1  port B granted this cycle (combinational).
- issue_valid  in  1  a long-latency op is issued this cycle; marks issue_rd busy.
- issue_rd  in  REG_ADDR_BITS  destination register of the issued op.
- chk_rs1, chk_rs2, chk_rd  in  REG_ADDR_BITS  operands of the instruction in decode.
- hazard  out  1  any checked register is busy (combinational).
- register_enable_write  out  1  bank write enable (registered).
- register_address_to_write  out  REG_ADDR_BITS  bank write address (registered).
- register_data_to_write  out  DATA_WIDTH  bank write data (registered).
- busy_vec  out  2**REG_ADDR_BITS  scoreboard contents, for debug.

Behaviour:
- Reset (sync):
  - register_enable_write=0, address=0, data=0.
  - busy_vec all 0.
  - Round-robin pointer favours A.
- Handshake: a transfer on a port occurs when valid && ready in the same cycle. Valid, rd and data stay stable until accepted.
- Arbitration, at most one grant per cycle:
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the port not granted most recently. The pointer updates only on a grant.
  - Neither valid: no grant, pointer holds.
- Write stage, one-cycle latency:
  - A grant in cycle T sets register_enable_write=1 in cycle T+1, with address and data taken from the granted port.
  - The bank commits at the end of T+1.
  - With no grant in T, enable=0 in T+1 and address/data hold their previous values.
- x0 handling:
  - A grant with rd=0 is accepted (ready=1, pointer advances) but produces enable=0.
  - issue_rd=0 never sets busy[0].
  - busy[0] is always 0.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd] at the edge.
  - register_enable_write=1 clears busy[register_address_to_write] at the same edge the bank commits.
  - Set and clear of the same index in the same cycle: set wins.
  - Issuing to an already-busy rd leaves the bit set. Decode must prevent this via hazard.
- hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]. It is computed from current register state only, with no bypass of the same-cycle write.
- Port A may write a register that is busy, because ALU results are not scoreboarded. That write does clear the bit; issue logic must not create this case.
- Reset asserted mid-operation drops the pending grant, the write stage and all busy bits on that edge. Requesters must re-present after reset.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and REG_ADDR_BITS defaults.
  - NUM_REGS = 1<<REG_ADDR_BITS.
  - Port-select encoding: PORT_A=0, PORT_B=1.
- One sub-module, regfile_scoreboard, holds busy_vec set/clear logic and the three-way hazard lookup.
- Arbitration and the write-stage registers stay in the top module.

Test Plan:
- Reset, then a_valid with a_rd=3, a_data=0x11 -> a_ready=1. Next cycle enable=1, addr=3, data=0x11. The cycle after, enable=0.
- a_valid and b_valid held together for 4 cycles (rd 5/6, data 0xA/0xB) -> grants alternate A,B,A,B. Write stage shows addr 5,6,5,6 on consecutive cycles.
- issue_valid with issue_rd=7 -> busy_vec[7]=1. chk_rs2=7 gives hazard=1. b writes rd=7 data 0x55 -> hazard drops the cycle after enable=1 for addr 7.
- issue_rd=9 together with a write-stage clear of 9 in the same cycle -> busy[9] stays 1.
- b_valid with b_rd=0 -> b_ready=1, enable stays 0. issue_rd=0 -> busy_vec[0]=0. chk_rs1=0 gives hazard=0.
- busy[4] set and a grant pending, then reset for 1 cycle -> next cycle busy_vec=0, enable=0, address=0, data=0, and pointer favours A when both are valid.
